// File: rtl/video_wr_ctrl_if.sv
// video_wr_ctrl_if: write-buffer request and pixel-gate bundle.
// master = frame write controller, slave = line/write buffer.
interface video_wr_ctrl_if #(
    parameter int AXI_ADDR_WIDTH = 32
) ();
    logic                      req_en;
    logic                      req_ready;
    logic [7:0]                burst_len;
    logic [AXI_ADDR_WIDTH-1:0] data_addr;
    logic                      frame_reset;
    logic                      line_wren;

    modport master (
        output req_en,
        output burst_len,
        output data_addr,
        output frame_reset,
        output line_wren,
        input  req_ready
    );

    modport slave (
        input  req_en,
        input  burst_len,
        input  data_addr,
        input  frame_reset,
        input  line_wren,
        output req_ready
    );
endinterface

// File: rtl/video_wr_ctrl.sv
// video_wr_ctrl: camera-side frame write controller, one burst per line.
// Optional VIDEO_WR_PINGPONG_EN: alternate frames land 16 MiB apart.
module video_wr_ctrl #(
    parameter int VIDEO_WR_DATA_WIDTH = 16,
    parameter int AXI_DATA_WIDTH      = 128,
    parameter int AXI_ADDR_WIDTH      = 32
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_ddr_init_done,
    input  logic [15:0]               i_wr_video_width,
    input  logic [15:0]               i_wr_video_high,
    input  logic                      i_wr_video_field,
    input  logic                      i_wr_video_valid,
    input  logic [AXI_ADDR_WIDTH-1:0] i_wr_video_base_addr,
    video_wr_ctrl_if.master           buff,
    output logic                      o_wr_frame_done,
    output logic                      o_wr_overflow,
    output logic [15:0]               o_video_width
);

    localparam int          RATIO      = AXI_DATA_WIDTH / VIDEO_WR_DATA_WIDTH;
    localparam int          RATIO_LOG2 = $clog2(RATIO);
    localparam logic [15:0] RATIO_MASK = 16'(RATIO - 1);
    localparam logic [3:0]  PHASE_LAST = 4'd12;

    typedef enum logic [5:0] {
        IDLE      = 6'b000001,
        CLEAR     = 6'b000010,
        RST_WAIT  = 6'b000100,
        CAPTURE   = 6'b001000,
        FLUSH     = 6'b010000,
        FRAME_END = 6'b100000
    } state_t;

    state_t                    state;
    logic [1:0]                init_sync;
    logic                      wr_en;
    logic                      field_d;
    logic                      valid_d;
    logic                      field_rise;
    logic                      field_fall;
    logic                      valid_fall;
    logic [3:0]                cnt;
    logic [AXI_ADDR_WIDTH-1:0] base_q;
    logic [15:0]               width_q;
    logic [15:0]               high_q;
    logic [15:0]               line_num;
    logic [15:0]               lines_cap;
    logic [3:0]                pending;
    logic                      req_en;
    logic                      frame_reset;
    logic                      frame_done;
    logic                      overflow;
    logic [7:0]                burst_len;
    logic [7:0]                burst_nxt;
    logic [15:0]               width_div;
    logic [AXI_ADDR_WIDTH-1:0] data_addr;
    logic [AXI_ADDR_WIDTH-1:0] line_off;
    logic [AXI_ADDR_WIDTH-1:0] frame_off;
    logic                      below_high;
    logic                      line_done;
    logic                      accept;
    logic                      last_accept;
    logic                      req_state;

    assign field_rise  = wr_en & i_wr_video_field & ~field_d;
    assign field_fall  = field_d & ~i_wr_video_field;
    assign valid_fall  = valid_d & ~i_wr_video_valid;
    assign below_high  = (lines_cap < high_q);
    assign line_done   = (state == CAPTURE) & valid_fall & below_high;
    assign accept      = req_en & buff.req_ready;
    assign last_accept = accept & ((line_num + 16'd1) == high_q);
    assign req_state   = (state == CAPTURE) | (state == FLUSH);

    // A partial AXI beat still costs a full beat, so round up.
    assign width_div = width_q >> RATIO_LOG2;
    assign burst_nxt = ((width_q & RATIO_MASK) == 16'd0)
                     ? 8'(width_div - 16'd1)
                     : 8'(width_div);

    assign line_off = AXI_ADDR_WIDTH'({line_num[11:0], 12'h000});

`ifdef VIDEO_WR_PINGPONG_EN
    logic frame_idx;

    // Flip the frame slot each time a full frame has been handed off.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            frame_idx <= 1'b0;
        end else if (frame_done) begin
            frame_idx <= ~frame_idx;
        end
    end

    assign frame_off = AXI_ADDR_WIDTH'({frame_idx, 24'h000000});
`else
    assign frame_off = '0;
`endif

    // Bring init_done into this domain; wr_en only changes between frames.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            init_sync <= 2'b00;
            wr_en     <= 1'b0;
        end else begin
            init_sync <= {init_sync[0], i_ddr_init_done};
            if (!i_wr_video_field) begin
                wr_en <= init_sync[1];
            end
        end
    end

    // Edge history of field/valid, held low while writes are disabled.
    always_ff @(posedge i_clk) begin
        if (i_reset || !wr_en) begin
            field_d <= 1'b0;
            valid_d <= 1'b0;
        end else begin
            field_d <= i_wr_video_field;
            valid_d <= i_wr_video_valid;
        end
    end

    // Frame sequencing, line accounting and the request handshake.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            base_q      <= '0;
            width_q     <= 16'd0;
            high_q      <= 16'd0;
            line_num    <= 16'd0;
            lines_cap   <= 16'd0;
            pending     <= 4'd0;
            req_en      <= 1'b0;
            data_addr   <= '0;
            burst_len   <= 8'd0;
            frame_reset <= 1'b1;
            frame_done  <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            frame_reset <= 1'b0;
            frame_done  <= last_accept;

            if (line_done) begin
                lines_cap <= lines_cap + 16'd1;
            end

            // Completion and acceptance in one cycle cancel out.
            if (line_done && !accept) begin
                if (pending == 4'hF) begin
                    overflow <= 1'b1;
                end else begin
                    pending <= pending + 4'd1;
                end
            end else if (accept && !line_done) begin
                pending <= pending - 4'd1;
            end

            if (req_en) begin
                if (buff.req_ready) begin
                    req_en   <= 1'b0;
                    line_num <= line_num + 16'd1;
                end
            end else if (req_state && (pending != 4'd0 || line_done)) begin
                req_en    <= 1'b1;
                data_addr <= base_q + line_off + frame_off;
            end

            unique case (state)
                IDLE: begin
                    if (field_rise) begin
                        state       <= CLEAR;
                        cnt         <= 4'd0;
                        frame_reset <= 1'b1;
                        base_q      <= i_wr_video_base_addr;
                        width_q     <= i_wr_video_width;
                        high_q      <= i_wr_video_high;
                        line_num    <= 16'd0;
                        lines_cap   <= 16'd0;
                        pending     <= 4'd0;
                    end
                end
                CLEAR: begin
                    if (cnt == 4'd0) begin
                        burst_len <= burst_nxt;
                    end
                    if (cnt == PHASE_LAST) begin
                        state <= RST_WAIT;
                        cnt   <= 4'd0;
                    end else begin
                        cnt         <= cnt + 4'd1;
                        frame_reset <= 1'b1;
                    end
                end
                RST_WAIT: begin
                    if (cnt == PHASE_LAST) begin
                        state <= CAPTURE;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                CAPTURE: begin
                    if (field_fall || lines_cap == high_q
                        || width_q == 16'd0) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (pending == 4'd0 && !req_en) begin
                        state <= FRAME_END;
                    end
                end
                FRAME_END: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign buff.line_wren = (state == CAPTURE) & i_wr_video_field
                          & i_wr_video_valid & wr_en & below_high;

    assign buff.req_en      = req_en;
    assign buff.burst_len   = burst_len;
    assign buff.data_addr   = data_addr;
    assign buff.frame_reset = frame_reset;
    assign o_wr_frame_done  = frame_done;
    assign o_wr_overflow    = overflow;
    assign o_video_width    = width_q;

endmodule

// File: tb/tb_video_wr_ctrl.sv
// tb_video_wr_ctrl: directed frames with a request scoreboard.
// Requests are queued at line end and popped on each accepted handshake.
module tb_video_wr_ctrl;

`ifdef VIDEO_WR_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  burst;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        init;
    logic        field;
    logic        valid;
    logic [15:0] width;
    logic [15:0] high;
    logic [31:0] base;
    logic        frame_done;
    logic        overflow;
    logic [15:0] vwidth;

    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   req_cnt = 0;
    int   d0;
    int   r0;
    bit   pp_idx = 1'b0;
    bit   seen_fr = 1'b0;
    bit   seen_wren = 1'b0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic        prev_req = 1'b0;
    logic        prev_acc = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [7:0]  prev_burst = '0;

    always #5 clk = ~clk;

    video_wr_ctrl_if #(.AXI_ADDR_WIDTH(32)) bif ();

    video_wr_ctrl dut (
        .i_clk                (clk),
        .i_reset              (rst),
        .i_ddr_init_done      (init),
        .i_wr_video_width     (width),
        .i_wr_video_high      (high),
        .i_wr_video_field     (field),
        .i_wr_video_valid     (valid),
        .i_wr_video_base_addr (base),
        .buff                 (bif),
        .o_wr_frame_done      (frame_done),
        .o_wr_overflow        (overflow),
        .o_video_width        (vwidth)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_addr(input logic [31:0] b,
                                             input int l);
        logic [31:0] a;
        a = b + (32'(l) * 32'h1000);
        if (PP && pp_idx) a = a + 32'h0100_0000;
        return a;
    endfunction

    function automatic logic [7:0] exp_burst(input logic [15:0] w);
        int beats;
        beats = (int'(w) + 7) / 8;
        return 8'(beats - 1);
    endfunction

    task automatic send_line(input int l, input bit push);
        valid = 1'b1;
        repeat (8) tick();
        valid = 1'b0;
        if (push) exp_q.push_back('{exp_addr(base, l), exp_burst(width)});
        repeat (6) tick();
    endtask

    task automatic frame(input logic [15:0] w, input logic [15:0] h,
                         input logic [31:0] b, input int n, input bit push);
        width = w;
        high  = h;
        base  = b;
        tick();
        field = 1'b1;
        repeat (30) tick();
        for (int l = 0; l < n; l++) send_line(l, push && (l < int'(h)));
        repeat (8) tick();
        field = 1'b0;
        repeat (4) tick();
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        field = 1'b0;
        valid = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        exp_q.delete();
        pp_idx = 1'b0;
        repeat (6) tick();
    endtask

    // Scoreboard pop, handshake spacing and hold checks, once per cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_acc) begin
                chk("req_gap", bif.req_en, 0);
            end else if (prev_req && bif.req_en) begin
                chk("addr_hold", bif.data_addr, prev_addr);
                chk("burst_hold", bif.burst_len, prev_burst);
            end
            if (bif.req_en && bif.req_ready) begin
                req_cnt++;
                chk("sb_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("req_addr", bif.data_addr, mon_e.addr);
                    chk("req_burst", bif.burst_len, mon_e.burst);
                end
            end
            if (frame_done) done_cnt++;
        end
        if (bif.frame_reset) seen_fr = 1'b1;
        if (bif.line_wren) seen_wren = 1'b1;
        prev_req   = bif.req_en;
        prev_acc   = bif.req_en & bif.req_ready;
        prev_addr  = bif.data_addr;
        prev_burst = bif.burst_len;
    end

    initial begin
        rst = 1'b1;
        init = 1'b1;
        field = 1'b0;
        valid = 1'b0;
        width = '0;
        high = '0;
        base = '0;
        bif.req_ready = 1'b1;
        tick();
        chk("rst_req_en", bif.req_en, 0);
        chk("rst_burst", bif.burst_len, 0);
        chk("rst_addr", bif.data_addr, 0);
        chk("rst_frame_reset", bif.frame_reset, 1);
        chk("rst_wren", bif.line_wren, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_vwidth", vwidth, 0);
        rst = 1'b0;
        repeat (6) tick();

        // Nominal 1920x4 frame with trigger and request timing.
        width = 16'd1920;
        high  = 16'd4;
        base  = 32'h1000_0000;
        d0 = done_cnt;
        tick();
        field = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            tick();
            chk("clear_frame_reset", bif.frame_reset, i <= 13);
        end
        chk("burst_1920", bif.burst_len, 239);
        chk("video_width", vwidth, 1920);
        repeat (12) tick();
        valid = 1'b1;
        #1;
        chk("pre_capture_wren", bif.line_wren, 0);
        tick();
        chk("capture_wren", bif.line_wren, 1);
        repeat (7) tick();
        valid = 1'b0;
        exp_q.push_back('{exp_addr(base, 0), exp_burst(width)});
        tick();
        chk("req_latency", bif.req_en, 1);
        chk("req_addr0_live", bif.data_addr, 32'h1000_0000);
        repeat (5) tick();
        for (int l = 1; l < 4; l++) send_line(l, 1'b1);
        repeat (8) tick();
        field = 1'b0;
        repeat (4) tick();
        chk("nom_sb_empty", exp_q.size(), 0);
        chk("nom_done", done_cnt - d0, 1);
        chk("nom_last_addr", bif.data_addr, 32'h1000_3000);
        pp_idx ^= 1'b1;

        // Burst rounding.
        frame(16'd1921, 16'd1, 32'h6000_0000, 1, 1'b1);
        chk("burst_1921", bif.burst_len, 240);
        pp_idx ^= 1'b1;
        frame(16'd8, 16'd1, 32'h6100_0000, 1, 1'b1);
        chk("burst_8", bif.burst_len, 0);
        pp_idx ^= 1'b1;

        // Degenerate frames issue nothing.
        d0 = done_cnt;
        r0 = req_cnt;
        frame(16'd1920, 16'd0, 32'h7000_0000, 2, 1'b0);
        frame(16'd0, 16'd2, 32'h7000_0000, 2, 1'b0);
        chk("degen_reqs", req_cnt - r0, 0);
        chk("degen_done", done_cnt - d0, 0);

        // Back-pressure over three lines.
        width = 16'd1920;
        high  = 16'd3;
        base  = 32'h3000_0000;
        d0 = done_cnt;
        bif.req_ready = 1'b0;
        tick();
        field = 1'b1;
        repeat (30) tick();
        for (int l = 0; l < 3; l++) send_line(l, 1'b1);
        chk("bp_req_held", bif.req_en, 1);
        chk("bp_addr", bif.data_addr, exp_addr(32'h3000_0000, 0));
        chk("bp_pending", dut.pending, 3);
        bif.req_ready = 1'b1;
        repeat (20) tick();
        chk("bp_sb_empty", exp_q.size(), 0);
        chk("bp_overflow", overflow, 0);
        chk("bp_done", done_cnt - d0, 1);
        field = 1'b0;
        repeat (4) tick();

        // Reset in CAPTURE after two lines.
        width = 16'd1920;
        high  = 16'd4;
        base  = 32'h2000_0000;
        tick();
        field = 1'b1;
        repeat (30) tick();
        send_line(0, 1'b1);
        send_line(1, 1'b1);
        chk("mid_sb_empty", exp_q.size(), 0);
        valid = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("mid_req_en", bif.req_en, 0);
        chk("mid_frame_reset", bif.frame_reset, 1);
        chk("mid_wren", bif.line_wren, 0);
        rst = 1'b0;
        pp_idx = 1'b0;
        r0 = req_cnt;
        repeat (5) tick();
        valid = 1'b0;
        repeat (8) tick();
        chk("mid_no_req", req_cnt - r0, 0);
        chk("mid_req_low", bif.req_en, 0);
        field = 1'b0;
        repeat (6) tick();

        // Overflow: 16 lines with the buffer stalled.
        width = 16'd1920;
        high  = 16'd20;
        base  = 32'h4000_0000;
        bif.req_ready = 1'b0;
        tick();
        field = 1'b1;
        repeat (30) tick();
        for (int l = 0; l < 15; l++) send_line(l, 1'b0);
        chk("ovf_not_yet", overflow, 0);
        send_line(15, 1'b0);
        chk("ovf_flag", overflow, 1);
        chk("ovf_pending", dut.pending, 15);
        do_reset();
        chk("ovf_cleared", overflow, 0);
        bif.req_ready = 1'b1;

        // DDR not ready: no frame activity at all.
        init = 1'b0;
        do_reset();
        seen_fr = 1'b0;
        seen_wren = 1'b0;
        r0 = req_cnt;
        frame(16'd1920, 16'd2, 32'h1000_0000, 2, 1'b0);
        chk("gate_frame_reset", seen_fr, 0);
        chk("gate_wren", seen_wren, 0);
        chk("gate_reqs", req_cnt - r0, 0);
        init = 1'b1;

        // Frame slot alternation across three frames.
        do_reset();
        frame(16'd64, 16'd1, 32'h5000_0000, 1, 1'b1);
        chk("pp_f1_addr", bif.data_addr, 32'h5000_0000);
        pp_idx ^= 1'b1;
        frame(16'd64, 16'd1, 32'h5000_0000, 1, 1'b1);
        chk("pp_f2_addr", bif.data_addr,
            PP ? 32'h5100_0000 : 32'h5000_0000);
        pp_idx ^= 1'b1;
        frame(16'd64, 16'd1, 32'h5000_0000, 1, 1'b1);
        chk("pp_f3_addr", bif.data_addr, 32'h5000_0000);
        chk("pp_sb_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_wr_ctrl.md
# video_wr_ctrl

Frame-level write controller for the video input (camera) path, the write-side counterpart of the LCD read controller. It watches the input field/valid stream, resets the write buffer at every frame start, and gates pixel writes into the line buffer. After each completed input line it issues one AXI burst write request per line to the write buffer, at the line's DDR address.

## Interface
Parameters:
- VIDEO_WR_DATA_WIDTH, 16, input pixel width in bits
- AXI_DATA_WIDTH, 128, AXI data bus width; RATIO = AXI_DATA_WIDTH/VIDEO_WR_DATA_WIDTH, power of two
- AXI_ADDR_WIDTH, 32, DDR address width

Ports. One clock; reset is synchronous and active-high.
- i_clk  in  1  system clock
- i_reset  in  1  synchronous active-high reset
- i_ddr_init_done  in  1  DDR calibration done, asynchronous; 2-flop synchronised internally
- i_wr_video_width  in  16  pixels per line
- i_wr_video_high  in  16  lines per frame
- i_wr_video_field  in  1  frame active (high for the whole frame)
- i_wr_video_valid  in  1  pixel valid (high for the active part of each line)
- i_wr_video_base_addr  in  AXI_ADDR_WIDTH  frame base byte address
- o_wr_buff_req_en  out  1  line write request
- i_wr_buff_req_ready  in  1  buffer accepts the request
- o_wr_buff_burst_len  out  8  AXI burst length minus 1
- o_wr_buff_data_addr  out  AXI_ADDR_WIDTH  line start address
- o_wr_buff_frame_reset  out  1  buffer/FIFO reset
- o_wr_buff_line_wren  out  1  pixel write enable into the line buffer
- o_wr_frame_done  out  1  one-cycle pulse when the last request of a frame is accepted
- o_wr_overflow  out  1  sticky; set when a line completes while the pending count is 15
- o_video_width  out  16  latched frame width

## Operation
- Write enable (wr_en):
  - Clears on reset.
  - In any cycle with field=0, wr_en takes the synchronised init_done; otherwise it holds.
  - While wr_en=0, the field/valid edge registers are forced to 0.
- Trigger: a field rising edge (field & ~field_d, qualified by wr_en) in IDLE.
  - On the trigger, latch base_addr, width and high.
  - A rising edge in any state other than IDLE is ignored.
- States (one-hot):
  - IDLE → CLEAR on trigger.
  - CLEAR → RST_WAIT when cnt_clear > 12 (13 cycles); o_wr_buff_frame_reset=1 throughout CLEAR.
  - RST_WAIT → CAPTURE when cnt_wait > 12 (13 cycles).
  - CAPTURE → FLUSH on a field falling edge, or when lines_captured == high.
  - FLUSH → END when pending == 0 and no request is outstanding.
  - END → IDLE, unconditionally.
- o_wr_buff_line_wren = field & valid & wr_en, only in CAPTURE, and only while lines_captured < high.
- Line complete: valid falling edge (valid_d & ~valid) in CAPTURE with lines_captured < high.
  - Increments lines_captured and pending (4-bit counter).
  - If pending is already 15, pending holds and o_wr_overflow sets. Only reset clears it.
- Request:
  - Raised when state is CAPTURE or FLUSH, pending > 0 and req_en = 0.
  - Held until req_en & ready; then deasserts the next cycle, line_num += 1 and pending -= 1.
  - A line completion in the same cycle as an acceptance leaves pending unchanged.
- Address: o_wr_buff_data_addr = base_latched + {line_num[11:0], 12'h000} + frame offset (see Configuration).
- Burst length: if width[log2(RATIO)-1:0] == 0, then width>>log2(RATIO) - 1; otherwise width>>log2(RATIO).
- Counters at trigger: line_num, lines_captured and pending are cleared.
- o_wr_frame_done: pulses on the acceptance that makes line_num == high.
- Degenerate frames: high=0 or width=0 produce no requests. The FSM passes CAPTURE → FLUSH → END immediately.

## Timing
- Reset values:
  - req_en=0, burst_len=0, addr=0 (latches cleared), frame_reset=1, line_wren=0, frame_done=0, overflow=0, video_width=0, state IDLE.
- Reset asserted mid-frame aborts immediately. No request is issued until the next trigger after wr_en is re-established.
- Trigger to first CAPTURE cycle: 27 cycles (1 IDLE→CLEAR, 13 CLEAR, 13 RST_WAIT).
  - Line timing must provide at least 27 cycles from field rise to first valid; pixels earlier are not written.
- Line completion to req_en high: 1 cycle, when nothing is outstanding.
- Address and burst_len are stable while req_en is high.
- Back-to-back requests are separated by at least 1 idle cycle.
- burst_len is registered one cycle after the width latch.

## Configuration
- VIDEO_WR_PINGPONG_EN defined:
  - A 1-bit frame index toggles on each o_wr_frame_done and is cleared by reset.
  - Address adds {frame_index, 24'h000000}, so alternate frames land 16 MiB apart.
- VIDEO_WR_PINGPONG_EN undefined: the frame offset is 0; every frame is written to the same base.

## Test plan
- Nominal frame: width=1920, high=4, base=0x1000_0000, ready tied high.
  - Required: burst_len=239.
  - Four requests at addr 0x1000_0000, 0x1000_1000, 0x1000_2000, 0x1000_3000.
  - frame_done pulses once; FSM returns to IDLE.
- Burst rounding: width=1921, RATIO=8 → burst_len=240. Width=8 → burst_len=0.
- Back-pressure: ready low for 3 full lines, then high.
  - Required: pending reaches 3; req_en stays high with addr 0x…0000 held.
  - After ready rises, three requests drain in order; no overflow.
- Overflow: ready low while 16 lines complete → o_wr_overflow=1 and pending=15. Reset clears the flag.
- Gating and reset:
  - init_done=0 → no frame_reset pulse and no wren.
  - Reset asserted in CAPTURE after line 2 → req_en=0, frame_reset=1 next cycle, state IDLE.
- Pingpong: with VIDEO_WR_PINGPONG_EN defined, frame 2 line 0 has addr = base + 0x0100_0000; frame 3 returns to base.
